// File: rtl/vga_timing_gen_if.sv
// Pixel bus of vga_timing_gen: upstream pixel request/RGB in, timed sync/DE/RGB out.
// pattern_sel is present only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if #(
    parameter int COLOR_W = 8,
    parameter int CNT_W   = 12
);
    logic               enable;
    logic [COLOR_W-1:0] red_in;
    logic [COLOR_W-1:0] green_in;
    logic [COLOR_W-1:0] blue_in;
`ifdef VGA_TEST_PATTERN_EN
    logic               pattern_sel;
`endif
    logic               pix_ce;
    logic [CNT_W-1:0]   x;
    logic [CNT_W-1:0]   y;
    logic               req;
    logic               de;
    logic               hsync;
    logic               vsync;
    logic               frame_start;
    logic               line_start;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;

`ifdef VGA_TEST_PATTERN_EN
    modport master (
        input  enable, red_in, green_in, blue_in, pattern_sel,
        output pix_ce, x, y, req, de, hsync, vsync, frame_start, line_start, red, green, blue
    );
    modport slave (
        output enable, red_in, green_in, blue_in, pattern_sel,
        input  pix_ce, x, y, req, de, hsync, vsync, frame_start, line_start, red, green, blue
    );
`else
    modport master (
        input  enable, red_in, green_in, blue_in,
        output pix_ce, x, y, req, de, hsync, vsync, frame_start, line_start, red, green, blue
    );
    modport slave (
        output enable, red_in, green_in, blue_in,
        input  pix_ce, x, y, req, de, hsync, vsync, frame_start, line_start, red, green, blue
    );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator with integer clock-enable pixel divider.
// Optional 8-bar colour test pattern is compiled in with VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
    parameter int H_DISPLAY = 1920,
    parameter int H_FP      = 88,
    parameter int H_SYNC    = 44,
    parameter int H_BP      = 148,
    parameter int V_DISPLAY = 1080,
    parameter int V_FP      = 4,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 36,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int CLK_DIV   = 1,
    parameter int COLOR_W   = 8,
    parameter int CNT_W     = 12
) (
    input  logic               clk,
    input  logic               reset,
    vga_timing_gen_if.master   bus
);
    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_DISPLAY + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_DISPLAY + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FP + V_SYNC);

    logic [DIV_W-1:0]   div_cnt;
    logic [CNT_W-1:0]   h_cnt;
    logic [CNT_W-1:0]   v_cnt;
    logic               pix_ce;
    logic               req;
    logic               hs_active;
    logic               vs_active;
    logic [COLOR_W-1:0] src_r;
    logic [COLOR_W-1:0] src_g;
    logic [COLOR_W-1:0] src_b;
    logic               de_q;
    logic               hsync_q;
    logic               vsync_q;
    logic               frame_start_q;
    logic               line_start_q;
    logic [COLOR_W-1:0] red_q;
    logic [COLOR_W-1:0] green_q;
    logic [COLOR_W-1:0] blue_q;

    // Gated by reset so the strobe stays low while reset is held even with CLK_DIV=1.
    assign pix_ce    = bus.enable && !reset && (div_cnt == DIV_LAST);
    assign req       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_active = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_active = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

`ifdef VGA_TEST_PATTERN_EN
    localparam int XW = CNT_W + 3;
    logic [2:0] bar;

    assign bar = 3'(({3'b000, h_cnt} << 3) / XW'(H_DISPLAY));

    always_comb begin
        src_r = bus.red_in;
        src_g = bus.green_in;
        src_b = bus.blue_in;
        if (bus.pattern_sel) begin
            src_r = {COLOR_W{bar[2]}};
            src_g = {COLOR_W{bar[1]}};
            src_b = {COLOR_W{bar[0]}};
        end
    end
`else
    assign src_r = bus.red_in;
    assign src_g = bus.green_in;
    assign src_b = bus.blue_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (bus.enable) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    // One pixel tick behind the counters; everything here shares that single stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_q    <= 1'b0;
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else if (pix_ce) begin
            de_q    <= req;
            hsync_q <= hs_active ? HSYNC_POL : ~HSYNC_POL;
            vsync_q <= vs_active ? VSYNC_POL : ~VSYNC_POL;
            red_q   <= req ? src_r : '0;
            green_q <= req ? src_g : '0;
            blue_q  <= req ? src_b : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            frame_start_q <= pix_ce && (h_cnt == '0) && (v_cnt == '0);
            line_start_q  <= pix_ce && (h_cnt == '0) && (v_cnt < V_ACT);
        end
    end

    assign bus.pix_ce      = pix_ce;
    assign bus.x           = h_cnt;
    assign bus.y           = v_cnt;
    assign bus.req         = req;
    assign bus.de          = de_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.frame_start = frame_start_q;
    assign bus.line_start  = line_start_q;
    assign bus.red         = red_q;
    assign bus.green       = green_q;
    assign bus.blue        = blue_q;
endmodule
